// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX operand forwarding selects and load-use stall control
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src2_used,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        ex_fwd_sel1,
    output logic [1:0]        ex_fwd_sel2,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    logic [REG_AW-1:0] ex_dest;
    logic              ex_wb_en;
    logic              ex_mem_read;
    logic [REG_AW-1:0] mem_dest;
    logic              mem_wb_en;
    logic [REG_AW-1:0] wb_dest;
    logic              wb_wb_en;

    logic              ex_hit1;
    logic              ex_hit2;
    logic              mem_hit1;
    logic              mem_hit2;
    logic              load_use;
    logic              bubble;
    logic [1:0]        next_sel1;
    logic [1:0]        next_sel2;

    // Today's EX/MEM producers become tomorrow's MEM/WB producers.
    always_comb begin
        ex_hit1  = ex_wb_en && (ex_dest != '0) && (id_src1 == ex_dest);
        ex_hit2  = ex_wb_en && (ex_dest != '0) && (id_src2 == ex_dest);
        mem_hit1 = mem_wb_en && (mem_dest != '0) && (id_src1 == mem_dest);
        mem_hit2 = mem_wb_en && (mem_dest != '0) && (id_src2 == mem_dest);
    end

    always_comb begin
        load_use = id_valid && ex_wb_en && ex_mem_read && (ex_dest != '0) &&
                   ((id_src1 == ex_dest) || (id_src2_used && (id_src2 == ex_dest)));
        stall    = load_use && !flush;
        bubble   = stall || flush || !id_valid;
    end

    always_comb begin
        next_sel1 = SEL_RF;
        if (ex_hit1) begin
            next_sel1 = SEL_MEM;
        end else if (mem_hit1) begin
            next_sel1 = SEL_WB;
        end
        next_sel2 = SEL_RF;
        if (ex_hit2) begin
            next_sel2 = SEL_MEM;
        end else if (mem_hit2) begin
            next_sel2 = SEL_WB;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_dest     <= '0;
            ex_wb_en    <= 1'b0;
            ex_mem_read <= 1'b0;
            mem_dest    <= '0;
            mem_wb_en   <= 1'b0;
            wb_dest     <= '0;
            wb_wb_en    <= 1'b0;
            ex_fwd_sel1 <= SEL_RF;
            ex_fwd_sel2 <= SEL_RF;
        end else begin
            mem_dest  <= ex_dest;
            mem_wb_en <= ex_wb_en;
            wb_dest   <= mem_dest;
            wb_wb_en  <= mem_wb_en;
            if (bubble) begin
                ex_dest     <= '0;
                ex_wb_en    <= 1'b0;
                ex_mem_read <= 1'b0;
                ex_fwd_sel1 <= SEL_RF;
                ex_fwd_sel2 <= SEL_RF;
            end else begin
                // Non-writers carry dest 0 so every stage holds a canonical entry.
                ex_dest     <= id_wb_en ? id_dest : '0;
                ex_wb_en    <= id_wb_en;
                ex_mem_read <= id_mem_read && id_wb_en;
                ex_fwd_sel1 <= next_sel1;
                ex_fwd_sel2 <= next_sel2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (wb_wb_en || (wb_dest == '0));
        end
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control-side counterpart of the datapath operand muxes. Generates the 2-bit select codes that steer the EX-stage 3-input operand muxes (register file / MEM-stage forward / WB-stage forward).
- Detects load-use hazards and raises a stall.
- Keeps its own shadow pipeline of destination-register info (EX, MEM, WB), so it needs only the ID-stage decode as input.

Parameters:
- REG_AW, 5, register-address width; register 0 is hard-wired zero and never forwarded.
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- id_valid  input  1  ID stage holds a real instruction
- id_src1  input  REG_AW  ID source register 1
- id_src2  input  REG_AW  ID source register 2
- id_src2_used  input  1  instruction reads src2 (R-type, store, branch)
- id_dest  input  REG_AW  ID destination register
- id_wb_en  input  1  ID instruction writes the register file
- id_mem_read  input  1  ID instruction is a load
- flush  input  1  squash the ID instruction (taken branch/jump)
- ex_fwd_sel1  output  2  registered select for EX operand-1 mux
- ex_fwd_sel2  output  2  registered select for EX operand-2 mux
- stall  output  1  combinational; hold PC and IF/ID, insert bubble
- stall_count  output  CNT_W  number of stall cycles since reset

Behaviour:
- Select encoding: 2'd0 = register file, 2'd1 = MEM-stage ALU result, 2'd2 = WB-stage result. 2'd3 is never driven.
- Shadow stages: ex_{dest,wb_en,mem_read}, mem_{dest,wb_en}, wb_{dest,wb_en}.
- Reset (rst_n = 0 at an edge):
  - All shadow wb_en/mem_read bits clear; dests clear to 0.
  - ex_fwd_sel1 = ex_fwd_sel2 = 0; stall_count = 0.
  - stall reads 0 during and immediately after reset.
- stall (combinational):
  - stall = id_valid & ex_wb_en & ex_mem_read & (ex_dest != 0) & ((id_src1 == ex_dest) | (id_src2_used & id_src2 == ex_dest)).
  - flush has priority: when flush = 1, stall = 0.
- Per rising edge, rst_n = 1:
  - mem <= ex; wb <= mem (always advance).
  - EX slot loads a bubble (wb_en = 0, mem_read = 0, dest = 0, sels = 0) if stall | flush | ~id_valid.
  - Otherwise the EX slot loads the ID fields, and the selects compare against the pre-edge ex/mem stages, which are the post-edge MEM/WB stages.
- Select computation, per source s:
  - sel = 1 if ex_wb_en & ex_dest != 0 & s == ex_dest.
  - Otherwise sel = 2 if mem_wb_en & mem_dest != 0 & s == mem_dest.
  - Otherwise sel = 0.
  - MEM beats WB when both match (youngest producer wins).
  - src2 is used for the compare even when id_src2_used = 0; a select on an unused operand is harmless.
- Latency: selects are valid in the cycle the instruction occupies EX, one edge after it was presented in ID.
- Load-use: stall lasts exactly one cycle. Next cycle the load is in MEM and the consumer re-evaluates; no stall, sel = 2 (load in WB when consumer reaches EX).
- stall_count increments on every edge where stall = 1. It saturates at all-ones, with no wrap.
- Back-to-back writers of the same register: the most recent wins (sel = 1).
- A load followed by an independent instruction, then a consumer, gives sel = 2 with no stall.

Test Plan:
- Reset hold: rst_n = 0 for 3 edges with random ID inputs -> sels = 0, stall = 0, stall_count = 0. Deassert -> first valid instruction's sels are 0.
- EX->EX forward: add r3 (dest 3, wb_en), then sub src1 = 3, src2 = 4 -> sub in EX shows ex_fwd_sel1 = 1, ex_fwd_sel2 = 0, no stall.
- WB forward and priority:
  - Writer r5, nop, reader src1 = 5 -> sel1 = 2.
  - Writers r5, r5, then reader -> sel1 = 1.
  - Reader src1 = 0 after writer r0 -> sel1 = 0.
- Load-use: lw r7, then add src2 = 7 (src2_used = 1) -> stall = 1 for exactly one cycle, EX bubble (sels 0). Next cycle, add in EX has sel2 = 2; stall_count = 1.
- Unused src2: lw r7, then addi src1 = 1, src2 = 7, src2_used = 0 -> no stall.
- Flush and saturation:
  - Flush during a load-use condition -> stall = 0 and EX gets a bubble.
  - With CNT_W = 2, force 5 stall cycles -> stall_count stops at 3.
